// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Read-after-write hazard scoreboard for the register file, placed between ID
//   and EXE. Each tracked register keeps a count of writes that have issued but
//   not yet written back. An instruction in ID is held while any source it reads
//   still has a pending write, or while its destination counter is saturated.
//   Addresses at or above NUM_REGS (the PC slot) are never tracked.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   clear            synchronous flush: every counter returns to zero next edge
//   issue_valid      ID holds a valid instruction
//   issue_wb_en      that instruction writes back to issue_dest
//   issue_dest       destination register of the ID instruction
//   src1, src2       source registers; src2 only matters when use_src2 is set
//   issue_fire       instruction leaves ID this cycle (issue_valid & ~stall)
//   stall            combinational hold to IF/ID
//   wb_en, wb_dest   write-back strobe and register, as seen by the register file
//   busy_mask        registered, bit i set while register i has a pending write
//   inflight         registered total of all pending writes
//   err_underflow    sticky, a write-back arrived for a register with none pending
//
// Handshake: issue_valid acts as valid and ~stall as ready. The instruction
// transfers (issue_fire) on a clock edge where both are high; while stalled, ID
// must hold its instruction stable. stall never depends on issue_fire, so there
// is no combinational loop.
module reg_scoreboard #(
  parameter int NUM_REGS = 15,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                issue_valid,
  input  logic                issue_wb_en,
  input  logic [3:0]          issue_dest,
  input  logic [3:0]          src1,
  input  logic [3:0]          src2,
  input  logic                use_src2,
  output logic                issue_fire,
  output logic                stall,
  input  logic                wb_en,
  input  logic [3:0]          wb_dest,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [5:0]          inflight,
  output logic                err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_d;
  logic [5:0]          sum_d;
  logic                underflow_d;

  logic src1_busy;
  logic src2_busy;
  logic dest_full;

  // Hazard detection looks only at the registered counters: a write-back in
  // this same cycle does not release the stall until the next cycle. Untracked
  // addresses match no entry and therefore never contribute.
  always_comb begin
    src1_busy = 1'b0;
    src2_busy = 1'b0;
    dest_full = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (src1 == 4'(r) && cnt_q[r] != '0)          src1_busy = 1'b1;
      if (src2 == 4'(r) && cnt_q[r] != '0)          src2_busy = 1'b1;
      if (issue_dest == 4'(r) && cnt_q[r] == CNT_MAX) dest_full = 1'b1;
    end
    stall      = issue_valid & (src1_busy | (use_src2 & src2_busy) |
                                (issue_wb_en & dest_full));
    issue_fire = issue_valid & ~stall;
  end

  // Next counter values. An issue and a write-back to the same register in one
  // cycle cancel out. A write-back with nothing pending leaves the counter at
  // zero and flags the error. clear squashes everything, including this
  // cycle's issue and write-back, and so cannot raise the error.
  always_comb begin
    logic inc;
    logic dec;
    underflow_d = 1'b0;
    sum_d       = '0;
    busy_d      = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc      = issue_fire & issue_wb_en & (issue_dest == 4'(r));
      dec      = wb_en & (wb_dest == 4'(r));
      cnt_d[r] = cnt_q[r];
      if (clear) begin
        cnt_d[r] = '0;
      end else if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec && !inc) begin
        if (cnt_q[r] == '0) underflow_d = 1'b1;
        else                cnt_d[r]    = cnt_q[r] - 1'b1;
      end
      busy_d[r] = (cnt_d[r] != '0);
      sum_d     = sum_d + 6'(cnt_d[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      busy_mask     <= '0;
      inflight      <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      busy_mask     <= busy_d;
      inflight      <= sum_d;
      err_underflow <= err_underflow | underflow_d;
    end
  end

endmodule
